// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder: synchronizes t_in, emits a pulse per level change, and keeps
// pending/overflow/total counts. Define TOGGLE_DECODER_TOT_CNT_EN to build the total-event counter.
module toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 8
) (
    input  logic             clk,
    input  logic             a_reset_n,
    input  logic             t_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    output logic [TOT_W-1:0] tot_cnt
);

    // Handshake: a pending event is offered while evt_valid is high; it is consumed on any rising
    // edge where evt_valid and evt_ready are both high. evt_ready with nothing pending is ignored.

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       pend_q;
    logic [CNT_W-1:0]       pend_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   evt;
    logic                   pop;
    logic                   pend_full;
    logic                   ovf_set;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], t_in};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // s_prev resets to 0 like the source T flip-flop, so a high t_in at release counts as one event.
    assign evt       = sync_q[SYNC_STAGES-1] ^ s_prev_q;
    assign evt_valid = (pend_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign pend_full = &pend_q;
    assign ovf_set   = evt & ~pop & pend_full;

    always_comb begin
        pend_d = pend_q;
        if (evt && !pop) begin
            if (!pend_full) begin
                pend_d = pend_q + 1'b1;
            end
        end else if (pop && !evt) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // A fresh overflow wins over a simultaneous clear so the loss is never hidden.
    assign ovf_d = ovf_set | (ovf_q & ~clr_ovf);

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            pulse_q <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pulse_q <= evt;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TOGGLE_DECODER_TOT_CNT_EN
    logic [TOT_W-1:0] tot_q;
    logic [TOT_W-1:0] tot_d;

    // Counts every detected event, including those dropped at saturation; wraps naturally.
    assign tot_d = evt ? tot_q + 1'b1 : tot_q;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            tot_q <= '0;
        end else begin
            tot_q <= tot_d;
        end
    end

    assign tot_cnt = tot_q;
`else
    assign tot_cnt = '0;
`endif

    assign evt_pulse = pulse_q;
    assign pend_cnt  = pend_q;
    assign ovf       = ovf_q;

endmodule
